// File: rtl/dma_sequencer_if.sv
// dma_sequencer_if
// Bundles the command, C64 bus and expansion-RAM signals of the DMA sequencer.
//   slave  : the sequencer side (receives command/bus inputs, drives DMA/address/strobe outputs)
//   master : the register block / bus glue side
// Signals:
//   PHI2, BA             C64 bus phase clock and bus-available
//   Execute, Cmd         one-CLK start pulse and command (00 stash, 01 fetch, 10 swap, 11 verify)
//   C64Start, RAMStart   initial addresses; Len byte count (0 = 65536)
//   FixC64, FixRAM       hold the respective address constant
//   Match                external comparator result for verify
//   DMA, DMARW           bus request and C64 read(1)/write(0) direction
//   C64A, RAMA           current addresses
//   RAMWE, Latch         one-CLK RAM write and C64 data capture strobes
//   Busy, Done           transfer in progress, one-CLK end pulse
//   VerifyErr, Remaining sticky verify mismatch, bytes left
interface dma_sequencer_if;
    logic        PHI2;
    logic        BA;
    logic        Execute;
    logic [1:0]  Cmd;
    logic [15:0] C64Start;
    logic [18:0] RAMStart;
    logic [15:0] Len;
    logic        FixC64;
    logic        FixRAM;
    logic        Match;
    logic        DMA;
    logic        DMARW;
    logic [15:0] C64A;
    logic [18:0] RAMA;
    logic        RAMWE;
    logic        Latch;
    logic        Busy;
    logic        Done;
    logic        VerifyErr;
    logic [15:0] Remaining;

    modport slave (
        input  PHI2, BA, Execute, Cmd, C64Start, RAMStart, Len, FixC64, FixRAM, Match,
        output DMA, DMARW, C64A, RAMA, RAMWE, Latch, Busy, Done, VerifyErr, Remaining
    );

    modport master (
        output PHI2, BA, Execute, Cmd, C64Start, RAMStart, Len, FixC64, FixRAM, Match,
        input  DMA, DMARW, C64A, RAMA, RAMWE, Latch, Busy, Done, VerifyErr, Remaining
    );
endinterface

// File: rtl/dma_sequencer.sv
// dma_sequencer
// Sequences C64 <-> expansion-RAM DMA transfers (stash, fetch, swap, verify),
// one byte per PHI2 period, timed from the falling edge of a synchronized PHI2.
// Ports:
//   CLK   system clock (at least 8x PHI2)
//   nRST  asynchronous active-low reset
//   bus   dma_sequencer_if.slave: command inputs, C64 bus inputs, address/strobe/status outputs
module dma_sequencer (
    input  logic           CLK,
    input  logic           nRST,
    dma_sequencer_if.slave bus
);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] ARM   = 3'd1;
    localparam logic [2:0] WAIT  = 3'd2;
    localparam logic [2:0] XFER  = 3'd3;
    localparam logic [2:0] XFER2 = 3'd4;
    localparam logic [2:0] FIN   = 3'd5;

    localparam logic [1:0] CMD_STASH  = 2'b00;
    localparam logic [1:0] CMD_FETCH  = 2'b01;
    localparam logic [1:0] CMD_SWAP   = 2'b10;
    localparam logic [1:0] CMD_VERIFY = 2'b11;

    logic [2:0]  state_q, state_d;
    logic        phi_s1_q, phi_s1_d;
    logic        phi_s2_q, phi_s2_d;
    logic        phi_s3_q, phi_s3_d;
    logic [1:0]  cmd_q, cmd_d;
    logic        fix_c64_q, fix_c64_d;
    logic        fix_ram_q, fix_ram_d;
    logic [15:0] c64a_q, c64a_d;
    logic [18:0] rama_q, rama_d;
    logic [15:0] rem_q, rem_d;
    logic        dma_q, dma_d;
    logic        ramwe_q, ramwe_d;
    logic        latch_q, latch_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        verr_q, verr_d;
    logic        adv_q, adv_d;
    logic        adv_addr_q, adv_addr_d;
    logic        fall;
    logic [2:0]  after_byte;

    always_comb begin
        phi_s1_d   = bus.PHI2;
        phi_s2_d   = phi_s1_q;
        phi_s3_d   = phi_s2_q;
        fall       = phi_s3_q & ~phi_s2_q;
        after_byte = (rem_q == 16'd1) ? FIN : (bus.BA ? XFER : WAIT);

        state_d    = state_q;
        cmd_d      = cmd_q;
        fix_c64_d  = fix_c64_q;
        fix_ram_d  = fix_ram_q;
        c64a_d     = c64a_q;
        rama_d     = rama_q;
        rem_d      = rem_q;
        dma_d      = dma_q;
        busy_d     = busy_q;
        verr_d     = verr_q;
        ramwe_d    = 1'b0;
        latch_d    = 1'b0;
        done_d     = 1'b0;
        adv_d      = 1'b0;
        adv_addr_d = 1'b0;

        // The advance is applied one CLK after the cycle-ending edge, i.e. while
        // RAMWE is high, so the RAM sees the address of the byte being written.
        if (adv_q) begin
            rem_d = rem_q - 16'd1;
            if (adv_addr_q) begin
                if (!fix_c64_q) c64a_d = c64a_q + 16'd1;
                if (!fix_ram_q) rama_d = rama_q + 19'd1;
            end
        end

        case (state_q)
            IDLE: begin
                if (bus.Execute) begin
                    cmd_d     = bus.Cmd;
                    fix_c64_d = bus.FixC64;
                    fix_ram_d = bus.FixRAM;
                    c64a_d    = bus.C64Start;
                    rama_d    = bus.RAMStart;
                    rem_d     = bus.Len;
                    verr_d    = 1'b0;
                    busy_d    = 1'b1;
                    state_d   = ARM;
                end
            end
            ARM: begin
                if (fall) begin
                    dma_d   = 1'b1;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (fall && bus.BA) state_d = XFER;
            end
            XFER: begin
                if (fall) begin
                    case (cmd_q)
                        CMD_SWAP: begin
                            latch_d = 1'b1;
                            state_d = XFER2;
                        end
                        CMD_VERIFY: begin
                            adv_d = 1'b1;
                            if (bus.Match) begin
                                adv_addr_d = 1'b1;
                                state_d    = after_byte;
                            end else begin
                                verr_d  = 1'b1;
                                state_d = FIN;
                            end
                        end
                        CMD_STASH: begin
                            ramwe_d    = 1'b1;
                            adv_d      = 1'b1;
                            adv_addr_d = 1'b1;
                            state_d    = after_byte;
                        end
                        default: begin
                            adv_d      = 1'b1;
                            adv_addr_d = 1'b1;
                            state_d    = after_byte;
                        end
                    endcase
                end
            end
            XFER2: begin
                if (fall) begin
                    ramwe_d    = 1'b1;
                    adv_d      = 1'b1;
                    adv_addr_d = 1'b1;
                    state_d    = after_byte;
                end
            end
            FIN: begin
                dma_d   = 1'b0;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q    <= IDLE;
            phi_s1_q   <= 1'b0;
            phi_s2_q   <= 1'b0;
            phi_s3_q   <= 1'b0;
            cmd_q      <= '0;
            fix_c64_q  <= 1'b0;
            fix_ram_q  <= 1'b0;
            c64a_q     <= '0;
            rama_q     <= '0;
            rem_q      <= '0;
            dma_q      <= 1'b0;
            ramwe_q    <= 1'b0;
            latch_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            verr_q     <= 1'b0;
            adv_q      <= 1'b0;
            adv_addr_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            phi_s1_q   <= phi_s1_d;
            phi_s2_q   <= phi_s2_d;
            phi_s3_q   <= phi_s3_d;
            cmd_q      <= cmd_d;
            fix_c64_q  <= fix_c64_d;
            fix_ram_q  <= fix_ram_d;
            c64a_q     <= c64a_d;
            rama_q     <= rama_d;
            rem_q      <= rem_d;
            dma_q      <= dma_d;
            ramwe_q    <= ramwe_d;
            latch_q    <= latch_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            verr_q     <= verr_d;
            adv_q      <= adv_d;
            adv_addr_q <= adv_addr_d;
        end
    end

    assign bus.DMA       = dma_q;
    assign bus.DMARW     = !((state_q == XFER && cmd_q == CMD_FETCH) || state_q == XFER2);
    assign bus.C64A      = c64a_q;
    assign bus.RAMA      = rama_q;
    assign bus.RAMWE     = ramwe_q;
    assign bus.Latch     = latch_q;
    assign bus.Busy      = busy_q;
    assign bus.Done      = done_q;
    assign bus.VerifyErr = verr_q;
    assign bus.Remaining = rem_q;
endmodule

// File: tb/tb_dma_sequencer.sv
// tb_dma_sequencer
// Scoreboard bench for dma_sequencer: stimulus pushes the expected output events
// (transfer start, counter advance, RAMWE, Latch, Done) into a queue and a monitor
// pops and compares them whenever the DUT shows such an event.
module tb_dma_sequencer;
    localparam int K_START = 0;
    localparam int K_ADV   = 1;
    localparam int K_WE    = 2;
    localparam int K_LATCH = 3;
    localparam int K_DONE  = 4;

    typedef struct {
        int          kind;
        logic [15:0] c64a;
        logic [18:0] rama;
        logic [15:0] rem;
        logic        dmarw;
        logic        verr;
    } item_t;

    logic CLK;
    logic nRST;
    logic last_dmarw;
    int   tests;
    int   fails;
    item_t sb_q[$];

    dma_sequencer_if bus ();

    dma_sequencer dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // PHI2 at 8 CLK periods, offset so its edges never line up with CLK
    initial begin
        bus.PHI2 = 1'b0;
        #3;
        forever #40 bus.PHI2 = ~bus.PHI2;
    end

    // DMARW during the PHI2 period that is just ending
    initial begin
        last_dmarw = 1'b1;
        forever begin
            @(negedge bus.PHI2);
            last_dmarw = bus.DMARW;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at 1ms, required completion");
        $fatal(1, "watchdog");
    end

    function automatic string kname(input int k);
        case (k)
            K_START: return "start";
            K_ADV:   return "adv";
            K_WE:    return "ramwe";
            K_LATCH: return "latch";
            default: return "done";
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input int kind, input logic [15:0] c, input logic [18:0] r,
                        input logic [15:0] rem, input logic dw, input logic ve);
        item_t it;
        it.kind  = kind;
        it.c64a  = c;
        it.rama  = r;
        it.rem   = rem;
        it.dmarw = dw;
        it.verr  = ve;
        sb_q.push_back(it);
    endtask

    task automatic pop_cmp(input int kind);
        item_t it;
        if (sb_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_%s: got event c64a=0x%0h rama=0x%0h rem=0x%0h, required no event",
                     kname(kind), bus.C64A, bus.RAMA, bus.Remaining);
        end else begin
            it = sb_q.pop_front();
            chk($sformatf("%s_kind", kname(it.kind)), 32'(kind), 32'(it.kind));
            chk($sformatf("%s_c64a", kname(it.kind)), 32'(bus.C64A), 32'(it.c64a));
            chk($sformatf("%s_rama", kname(it.kind)), 32'(bus.RAMA), 32'(it.rama));
            chk($sformatf("%s_remaining", kname(it.kind)), 32'(bus.Remaining), 32'(it.rem));
            if (kind == K_START || kind == K_DONE)
                chk($sformatf("%s_verifyerr", kname(it.kind)), 32'(bus.VerifyErr), 32'(it.verr));
            else
                chk($sformatf("%s_dmarw", kname(it.kind)), 32'(last_dmarw), 32'(it.dmarw));
        end
    endtask

    // Monitor
    initial begin
        logic [15:0] prev_rem;
        logic        prev_busy;
        prev_rem  = '0;
        prev_busy = 1'b0;
        forever begin
            @(negedge CLK);
            if (nRST) begin
                if (bus.Busy && !prev_busy) pop_cmp(K_START);
                else if (bus.Remaining != prev_rem) pop_cmp(K_ADV);
                if (bus.RAMWE || bus.Latch)
                    chk("ramwe_latch_exclusive", 32'(bus.RAMWE & bus.Latch), 32'd0);
                if (bus.RAMWE) pop_cmp(K_WE);
                if (bus.Latch) pop_cmp(K_LATCH);
                if (bus.Done) begin
                    pop_cmp(K_DONE);
                    chk("done_dma_low", 32'(bus.DMA), 32'd0);
                    chk("done_busy_low", 32'(bus.Busy), 32'd0);
                end
            end
            prev_rem  = bus.Remaining;
            prev_busy = bus.Busy;
        end
    end

    task automatic start(input logic [1:0] cmd, input logic [15:0] c64, input logic [18:0] ram,
                         input logic [15:0] len, input logic fc, input logic fr);
        @(negedge CLK);
        bus.Cmd      = cmd;
        bus.C64Start = c64;
        bus.RAMStart = ram;
        bus.Len      = len;
        bus.FixC64   = fc;
        bus.FixRAM   = fr;
        bus.Execute  = 1'b1;
        @(negedge CLK);
        bus.Execute  = 1'b0;
    endtask

    task automatic wait_rem(input string name, input logic [15:0] v, input int budget);
        int n = 0;
        while (bus.Remaining !== v && n < budget) begin
            @(negedge CLK);
            n++;
        end
        chk($sformatf("%s_timeout", name), 32'(n >= budget), 32'd0);
    endtask

    task automatic wait_done(input string name, input int budget);
        int n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (!bus.Done && n < budget);
        chk($sformatf("%s_timeout", name), 32'(n >= budget), 32'd0);
    endtask

    task automatic check_reset_vals(input string p);
        chk({p, "_dma"},       32'(bus.DMA),       32'd0);
        chk({p, "_dmarw"},     32'(bus.DMARW),     32'd1);
        chk({p, "_ramwe"},     32'(bus.RAMWE),     32'd0);
        chk({p, "_latch"},     32'(bus.Latch),     32'd0);
        chk({p, "_busy"},      32'(bus.Busy),      32'd0);
        chk({p, "_done"},      32'(bus.Done),      32'd0);
        chk({p, "_verifyerr"}, 32'(bus.VerifyErr), 32'd0);
        chk({p, "_c64a"},      32'(bus.C64A),      32'd0);
        chk({p, "_rama"},      32'(bus.RAMA),      32'd0);
        chk({p, "_remaining"}, 32'(bus.Remaining), 32'd0);
    endtask

    initial begin
        tests        = 0;
        fails        = 0;
        nRST         = 1'b1;
        bus.BA       = 1'b1;
        bus.Execute  = 1'b0;
        bus.Cmd      = 2'b00;
        bus.C64Start = '0;
        bus.RAMStart = '0;
        bus.Len      = '0;
        bus.FixC64   = 1'b0;
        bus.FixRAM   = 1'b0;
        bus.Match    = 1'b1;
        #2 nRST = 1'b0;
        #1 check_reset_vals("por");
        repeat (3) @(negedge CLK);
        nRST = 1'b1;

        // Stash, Len=3, RAM address wraps; a second Execute mid-transfer is ignored
        push(K_START, 16'h1000, 19'h7FFFF, 16'd3, 1'b1, 1'b0);
        push(K_WE,    16'h1000, 19'h7FFFF, 16'd3, 1'b1, 1'b0);
        push(K_ADV,   16'h1001, 19'h00000, 16'd2, 1'b1, 1'b0);
        push(K_WE,    16'h1001, 19'h00000, 16'd2, 1'b1, 1'b0);
        push(K_ADV,   16'h1002, 19'h00001, 16'd1, 1'b1, 1'b0);
        push(K_WE,    16'h1002, 19'h00001, 16'd1, 1'b1, 1'b0);
        push(K_ADV,   16'h1003, 19'h00002, 16'd0, 1'b1, 1'b0);
        push(K_DONE,  16'h1003, 19'h00002, 16'd0, 1'b1, 1'b0);
        start(2'b00, 16'h1000, 19'h7FFFF, 16'd3, 1'b0, 1'b0);
        wait_rem("stash_rem2", 16'd2, 200);
        start(2'b01, 16'hBEEF, 19'h12345, 16'd9, 1'b1, 1'b1);
        wait_done("stash_done", 200);

        // Fetch, Len=4, bus withdrawn for two PHI2 periods after byte 2
        push(K_START, 16'h2000, 19'h00100, 16'd4, 1'b0, 1'b0);
        push(K_ADV,   16'h2001, 19'h00101, 16'd3, 1'b0, 1'b0);
        push(K_ADV,   16'h2002, 19'h00102, 16'd2, 1'b0, 1'b0);
        push(K_ADV,   16'h2003, 19'h00103, 16'd1, 1'b0, 1'b0);
        push(K_ADV,   16'h2004, 19'h00104, 16'd0, 1'b0, 1'b0);
        push(K_DONE,  16'h2004, 19'h00104, 16'd0, 1'b0, 1'b0);
        start(2'b01, 16'h2000, 19'h00100, 16'd4, 1'b0, 1'b0);
        wait_rem("fetch_rem2", 16'd2, 200);
        @(posedge bus.PHI2);
        bus.BA = 1'b0;
        repeat (2) @(posedge bus.PHI2);
        bus.BA = 1'b1;
        wait_done("fetch_done", 300);

        // Swap, Len=1, C64 address held
        push(K_START, 16'h3000, 19'h00200, 16'd1, 1'b1, 1'b0);
        push(K_LATCH, 16'h3000, 19'h00200, 16'd1, 1'b1, 1'b0);
        push(K_WE,    16'h3000, 19'h00200, 16'd1, 1'b0, 1'b0);
        push(K_ADV,   16'h3000, 19'h00201, 16'd0, 1'b0, 1'b0);
        push(K_DONE,  16'h3000, 19'h00201, 16'd0, 1'b0, 1'b0);
        start(2'b10, 16'h3000, 19'h00200, 16'd1, 1'b1, 1'b0);
        wait_done("swap_done", 200);

        // Verify, Len=4, mismatch on byte 2
        push(K_START, 16'h4000, 19'h00300, 16'd4, 1'b1, 1'b0);
        push(K_ADV,   16'h4001, 19'h00301, 16'd3, 1'b1, 1'b0);
        push(K_ADV,   16'h4001, 19'h00301, 16'd2, 1'b1, 1'b0);
        push(K_DONE,  16'h4001, 19'h00301, 16'd2, 1'b1, 1'b1);
        start(2'b11, 16'h4000, 19'h00300, 16'd4, 1'b0, 1'b0);
        wait_rem("verify_rem3", 16'd3, 200);
        bus.Match = 1'b0;
        wait_done("verify_done", 200);
        bus.Match = 1'b1;

        // A new Execute clears the sticky VerifyErr
        push(K_START, 16'h4100, 19'h00400, 16'd1, 1'b1, 1'b0);
        push(K_ADV,   16'h4101, 19'h00401, 16'd0, 1'b1, 1'b0);
        push(K_DONE,  16'h4101, 19'h00401, 16'd0, 1'b1, 1'b0);
        start(2'b11, 16'h4100, 19'h00400, 16'd1, 1'b0, 1'b0);
        wait_done("verify2_done", 200);

        // Len=0 (65536) with both addresses held: Remaining wraps 0 -> FFFF, then
        // reset lands in the middle of a transfer cycle
        push(K_START, 16'h5000, 19'h00500, 16'h0000, 1'b1, 1'b0);
        for (int unsigned i = 0; i < 6; i++) begin
            push(K_WE,  16'h5000, 19'h00500, 16'(16'h0000 - i),     1'b1, 1'b0);
            push(K_ADV, 16'h5000, 19'h00500, 16'(16'hFFFF - i),     1'b1, 1'b0);
        end
        start(2'b00, 16'h5000, 19'h00500, 16'h0000, 1'b1, 1'b1);
        wait_rem("len0_remFFFA", 16'hFFFA, 300);
        repeat (2) @(negedge CLK);
        chk("len0_busy_before_reset", 32'(bus.Busy), 32'd1);
        chk("len0_dma_before_reset", 32'(bus.DMA), 32'd1);
        #2 nRST = 1'b0;
        #1 check_reset_vals("midxfer_reset");
        #20;
        @(negedge CLK);
        nRST = 1'b1;
        repeat (48) @(negedge CLK);
        chk("post_reset_busy", 32'(bus.Busy), 32'd0);
        chk("post_reset_dma", 32'(bus.DMA), 32'd0);

        repeat (4) @(negedge CLK);
        chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/dma_sequencer.md
DMA_SEQUENCER -- requirements
Module: dma_sequencer

Interface
REQ-001 SHALL have exactly one clock, CLK, and one reset, nRST; reset is asynchronous and active-low.
REQ-002 Ports (name  direction  width  meaning):
 CLK  in  1  system clock, at least 8x PHI2.
 nRST  in  1  async active-low reset.
 PHI2  in  1  C64 bus phase clock, asynchronous to CLK.
 BA  in  1  C64 bus available, high = DMA cycle permitted.
 Execute  in  1  start command, one-CLK pulse from register block.
 Cmd  in  2  00 stash (C64->RAM), 01 fetch (RAM->C64), 10 swap, 11 verify.
 C64Start  in  16  initial C64 address.
 RAMStart  in  19  initial expansion-RAM address.
 Len  in  16  byte count; 0 means 65536.
 FixC64  in  1  hold C64 address constant.
 FixRAM  in  1  hold RAM address constant.
 Match  in  1  external comparator, 1 = C64 byte equals RAM byte.
 DMA  out  1  request bus (feeds glue DMA input).
 DMARW  out  1  1 = C64 bus read, 0 = C64 bus write (feeds glue DMARW).
 C64A  out  16  current C64 address.
 RAMA  out  19  current RAM address.
 RAMWE  out  1  one-CLK RAM write strobe.
 Latch  out  1  one-CLK strobe capturing C64 data bus.
 Busy  out  1  transfer in progress.
 Done  out  1  one-CLK end-of-transfer pulse.
 VerifyErr  out  1  sticky verify mismatch flag.
 Remaining  out  16  bytes left (0 with Busy=0 after full transfer).

Function
REQ-003 PHI2 SHALL pass a 2-flop synchronizer; F = one-CLK event on synced 1->0; edges use synced signal only.
REQ-004 States SHALL be IDLE, ARM, WAIT, XFER, XFER2, FIN.
REQ-005 IDLE: Execute=1 latches Cmd, Fix flags, C64A<=C64Start, RAMA<=RAMStart, Remaining<=Len, clears VerifyErr, Busy<=1, -> ARM; Execute while Busy=1 SHALL be ignored.
REQ-006 ARM: on F assert DMA, -> WAIT.
REQ-007 WAIT: on F with BA=1 -> XFER (the PHI2 period now starting is a transfer cycle); BA=0 stays WAIT; DMA stays 1.
REQ-008 DMARW SHALL be 1 in XFER for stash/swap/verify, 0 for fetch; 0 in XFER2; 1 in all other states.
REQ-009 On F ending XFER: stash -> RAMWE; fetch -> none; verify -> compare Match; swap -> Latch, -> XFER2 without advancing.
REQ-010 On F ending XFER2 (swap): RAMWE, then advance.
REQ-011 Advance: C64A+1 mod 2^16 unless FixC64; RAMA+1 mod 2^19 (0x7FFFF->0x00000) unless FixRAM; Remaining-1 mod 2^16.
REQ-012 After advance: Remaining old value 1 -> FIN; else BA=1 at that F -> XFER (back-to-back), BA=0 -> WAIT. Len=0 SHALL yield 65536 transfers.
REQ-013 XFER2 SHALL start on the F ending XFER regardless of BA.
REQ-014 Verify with Match=0 at cycle-ending F: VerifyErr<=1, no advance of that byte's counters is performed except Remaining-1, -> FIN immediately.
REQ-015 FIN: DMA<=0, DMARW<=1, Busy<=0, Done=1 for exactly one CLK, -> IDLE; C64A/RAMA/Remaining hold final values.
REQ-016 RAMWE and Latch SHALL be registered, asserted the CLK after F detect, never both in one CLK.

Reset
REQ-017 nRST low SHALL force IDLE, DMA=0, DMARW=1, RAMWE=0, Latch=0, Busy=0, Done=0, VerifyErr=0, C64A=0, RAMA=0, Remaining=0, synchronizer=0, immediately and without CLK.
REQ-018 nRST asserted mid-transfer SHALL abort with no further strobes; release resumes in IDLE.

Verification
REQ-019 Reset: drive nRST=0 mid-XFER -> all outputs at REQ-017 values same instant, no RAMWE after release.
REQ-020 Stash Len=3, C64Start=0x1000, RAMStart=0x7FFFF, BA=1 -> 3 RAMWE pulses, RAMA 0x7FFFF->0x00000->0x00001->0x00002, C64A ends 0x1003, DMARW=1, Done once, DMA drops.
REQ-021 Fetch Len=4, BA=0 for 2 PHI2 periods after byte 2 -> DMARW=0 in transfer cycles, counters frozen in WAIT, Remaining ends 0, no RAMWE.
REQ-022 Swap Len=1, FixC64=1 -> XFER DMARW=1 + Latch, then XFER2 DMARW=0 + RAMWE, C64A unchanged, RAMA+1.
REQ-023 Verify Len=4, Match=0 on byte 2 -> VerifyErr=1, Remaining=2, Done pulse, DMA=0; second Execute clears VerifyErr.
REQ-024 Len=0, FixC64=1, FixRAM=1 -> exactly 65536 transfer cycles, Remaining wraps to 0 at Done.
